// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, default
// address map and instruction word width.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_BYTE0 = 3'd2,
        S_BYTE1 = 3'd3,
        S_BYTE2 = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int          WORD_W        = 24;
    localparam logic [23:0] DEF_BASE_ADDR = 24'd10;
    localparam logic [23:0] DEF_ADDR_STEP = 24'd3;

endpackage

// File: rtl/instr_byte_packer.sv
// Packs a byte stream MSB-first into one instruction word; the first byte
// of a word ends up in the top byte after three shifts.
module instr_byte_packer
    import loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-1:0] r_word;

    // Shift register: clear wins over load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= 24'd0;
        end else if (i_clr) begin
            r_word <= 24'd0;
        end else if (i_load) begin
            r_word <= {r_word[WORD_W-9:0], i_byte};
        end else begin
            r_word <= r_word;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/instr_loader.sv
// Streams a header byte N plus 3*N bytes into instruction memory at the PC
// fetch addresses, holding the CPU stalled until the last word is written.
module instr_loader
    import loader_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [23:0] ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_im_we,
    output logic [23:0] o_im_addr,
    output logic [23:0] o_im_wdata,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic [8:0]  o_words_loaded
);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_in_ready;
    logic        r_im_we;
    logic        r_cpu_hold;
    logic        r_done;
    logic [23:0] r_addr;
    logic [7:0]  r_left;
    logic [8:0]  r_words;
    logic        w_hs;
    logic        w_start;
    logic        w_take_count;
    logic        w_shift;
    logic        w_step;
    logic        w_busy_in;
    logic [23:0] w_word;

    assign w_hs         = i_in_valid & r_in_ready;
    assign w_start      = ((r_state == S_IDLE) || (r_state == S_DONE)) & i_start & ~i_abort;
    assign w_take_count = (r_state == S_COUNT) & w_hs & ~i_abort;
    assign w_busy_in    = (r_state == S_BYTE0) || (r_state == S_BYTE1) || (r_state == S_BYTE2);
    assign w_shift      = w_busy_in & w_hs & ~i_abort;
    assign w_step       = (r_state == S_WRITE) & ~i_abort;

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_next_state = S_COUNT;
                else         w_next_state = r_state;
            end
            S_COUNT: begin
                if (w_hs) w_next_state = (i_in_data == 8'd0) ? S_DONE : S_BYTE0;
                else      w_next_state = r_state;
            end
            S_BYTE0: begin
                if (w_hs) w_next_state = S_BYTE1;
                else      w_next_state = r_state;
            end
            S_BYTE1: begin
                if (w_hs) w_next_state = S_BYTE2;
                else      w_next_state = r_state;
            end
            S_BYTE2: begin
                if (w_hs) w_next_state = S_WRITE;
                else      w_next_state = r_state;
            end
            S_WRITE: begin
                if (r_left == 8'd1) w_next_state = S_DONE;
                else                w_next_state = S_BYTE0;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (i_abort) w_next_state = S_IDLE;
        else         w_next_state = w_next_state;
    end

    // State register with outputs pre-decoded from the next state so they are flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == S_COUNT) || (w_next_state == S_BYTE0) ||
                          (w_next_state == S_BYTE1) || (w_next_state == S_BYTE2);
            r_im_we    <= (w_next_state == S_WRITE);
            r_cpu_hold <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done     <= (w_next_state == S_DONE);
        end
    end

    // Address, remaining-word and loaded-word counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= BASE_ADDR;
            r_left  <= 8'd0;
            r_words <= 9'd0;
        end else if (w_start) begin
            r_addr  <= BASE_ADDR;
            r_left  <= 8'd0;
            r_words <= 9'd0;
        end else if (w_take_count) begin
            r_left  <= i_in_data;
        end else if (w_step) begin
            r_addr  <= r_addr + ADDR_STEP;
            r_left  <= r_left - 8'd1;
            r_words <= r_words + 9'd1;
        end else begin
            r_addr  <= r_addr;
            r_left  <= r_left;
            r_words <= r_words;
        end
    end

    instr_byte_packer u_packer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_start),
        .i_load  (w_shift),
        .i_byte  (i_in_data),
        .o_word  (w_word)
    );

    assign o_in_ready     = r_in_ready;
    assign o_im_we        = r_im_we;
    assign o_im_addr      = r_addr;
    assign o_im_wdata     = w_word;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_done         = r_done;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a stream-level reference model checked every cycle,
// plus directed loads with literal expectations.
module tb_instr_loader;

    localparam int BASE = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        o_in_ready;
    logic        o_im_we;
    logic [23:0] o_im_addr;
    logic [23:0] o_im_wdata;
    logic        o_cpu_hold;
    logic        o_done;
    logic [8:0]  o_words_loaded;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream[$];
    logic [23:0] cap_addr[$];
    logic [23:0] cap_data[$];

    // Reference model state: what the loader must be doing this cycle.
    bit          m_active, m_done, m_hdr, m_wr;
    int          m_left, m_buf, m_words;
    logic [23:0] m_word;

    instr_loader dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_in_data      (in_data),
        .i_in_valid     (in_valid),
        .o_in_ready     (o_in_ready),
        .o_im_we        (o_im_we),
        .o_im_addr      (o_im_addr),
        .o_im_wdata     (o_im_wdata),
        .o_cpu_hold     (o_cpu_hold),
        .o_done         (o_done),
        .o_words_loaded (o_words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_hdr = 0; m_wr = 0;
        m_left = 0; m_buf = 0; m_words = 0; m_word = 24'd0;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("rst_wdata", {8'd0, o_im_wdata}, 32'd0);
        end
        chk("in_ready", {31'd0, o_in_ready}, {31'd0, m_active && !m_wr});
        chk("im_we", {31'd0, o_im_we}, {31'd0, m_wr});
        chk("im_addr", {8'd0, o_im_addr}, BASE + 3 * m_words);
        if (m_wr) chk("im_wdata", {8'd0, o_im_wdata}, {8'd0, m_word});
        chk("cpu_hold", {31'd0, o_cpu_hold}, {31'd0, m_active});
        chk("done", {31'd0, o_done}, {31'd0, m_done});
        chk("words", {23'd0, o_words_loaded}, m_words);
        if (o_im_we) begin
            cap_addr.push_back(o_im_addr);
            cap_data.push_back(o_im_wdata);
        end
        if (rst_n) begin
            if (abort) begin
                m_active = 0; m_done = 0; m_wr = 0;
            end else if (start && !m_active) begin
                m_active = 1; m_done = 0; m_hdr = 1; m_words = 0; m_buf = 0; m_wr = 0;
            end else if (m_wr) begin
                m_wr = 0; m_words++; m_left--;
                if (m_left == 0) begin
                    m_active = 0; m_done = 1;
                end
            end else if (m_active && in_valid) begin
                if (m_hdr) begin
                    m_hdr = 0;
                    if (in_data == 8'd0) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_left = in_data;
                    end
                end else begin
                    m_word = {m_word[15:0], in_data};
                    m_buf++;
                    if (m_buf == 3) begin
                        m_buf = 0; m_wr = 1;
                    end
                end
            end
        end
    end

    task automatic run_stream(input int vprob, input bit do_start, input bit rand_start,
                              input bit wait_done);
        int idx = 0;
        int cyc = 0;
        int budget = stream.size() * 40 + 100;
        bit hs;
        if (do_start) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        while (idx < stream.size() && cyc < budget) begin
            in_valid = ($urandom_range(99) < vprob);
            in_data  = in_valid ? stream[idx] : 8'($urandom);
            start    = rand_start && ($urandom_range(15) == 0);
            @(negedge clk);
            hs = in_valid && o_in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < stream.size()) chk("stream_timeout", idx, stream.size());
        if (wait_done) begin
            for (int c = 0; c < 50 && !o_done; c++) begin
                @(posedge clk); #1;
            end
            chk("done_reached", {31'd0, o_done}, 32'd1);
        end
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic check_two_word(input string tag);
        chk({tag, "_nwr"}, cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            chk({tag, "_a0"}, {8'd0, cap_addr[0]}, 32'h00000A);
            chk({tag, "_d0"}, {8'd0, cap_data[0]}, 32'hA1B2C3);
            chk({tag, "_a1"}, {8'd0, cap_addr[1]}, 32'h00000D);
            chk({tag, "_d1"}, {8'd0, cap_data[1]}, 32'h142536);
        end
        chk({tag, "_words"}, {23'd0, o_words_loaded}, 32'd2);
        chk({tag, "_hold"}, {31'd0, o_cpu_hold}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_ready", {31'd0, o_in_ready}, 32'd0);
        chk("rst_addr", {8'd0, o_im_addr}, 32'h00000A);
        chk("rst_wdata_rel", {8'd0, o_im_wdata}, 32'd0);
        chk("rst_words", {23'd0, o_words_loaded}, 32'd0);

        // Two-word load, valid held high, then with backpressure.
        clear_cap();
        stream = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'h14, 8'h25, 8'h36};
        run_stream(100, 1'b1, 1'b0, 1'b1);
        check_two_word("two_word");
        clear_cap();
        run_stream(50, 1'b1, 1'b0, 1'b1);
        check_two_word("backpress");

        // Zero-word load: done right after the header edge, no write.
        clear_cap();
        stream = '{8'h00};
        run_stream(100, 1'b1, 1'b0, 1'b0);
        chk("n0_done_next", {31'd0, o_done}, 32'd1);
        chk("n0_nwr", cap_addr.size(), 0);

        // Abort inside a word, then a clean reload.
        clear_cap();
        stream = '{8'h01, 8'hAA, 8'hBB};
        run_stream(100, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_nwr", cap_addr.size(), 0);
        chk("abort_hold", {31'd0, o_cpu_hold}, 32'd0);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        stream = '{8'h01, 8'h11, 8'h22, 8'h33};
        run_stream(100, 1'b1, 1'b0, 1'b1);
        chk("reload_nwr", cap_addr.size(), 1);
        if (cap_addr.size() == 1) begin
            chk("reload_a", {8'd0, cap_addr[0]}, 32'h00000A);
            chk("reload_d", {8'd0, cap_data[0]}, 32'h112233);
        end

        // Asynchronous reset while in the middle of a word.
        clear_cap();
        stream = '{8'h01, 8'hAA};
        run_stream(100, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_hold", {31'd0, o_cpu_hold}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_hold", {31'd0, o_cpu_hold}, 32'd0);
        chk("arst_we", {31'd0, o_im_we}, 32'd0);
        chk("arst_ready", {31'd0, o_in_ready}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        stream = '{8'h01, 8'h11, 8'h22, 8'h33};
        run_stream(100, 1'b1, 1'b0, 1'b1);
        chk("post_rst_nwr", cap_addr.size(), 1);
        if (cap_addr.size() == 1) chk("post_rst_a", {8'd0, cap_addr[0]}, 32'h00000A);

        // Randomized loads with random stalls and stray Start pulses.
        for (int t = 0; t < 10; t++) begin
            int n = $urandom_range(6);
            stream.delete();
            stream.push_back(8'(n));
            for (int b = 0; b < 3 * n; b++) stream.push_back(8'($urandom));
            run_stream($urandom_range(100, 30), 1'b1, 1'b1, 1'b1);
        end

        // Largest load: last word lands at BASE + 3*254.
        clear_cap();
        stream.delete();
        stream.push_back(8'd255);
        for (int b = 0; b < 765; b++) stream.push_back(8'($urandom));
        run_stream(100, 1'b1, 1'b0, 1'b1);
        chk("n255_nwr", cap_addr.size(), 255);
        if (cap_addr.size() == 255) chk("n255_last_a", {8'd0, cap_addr[254]}, 32'h000304);
        chk("n255_words", {23'd0, o_words_loaded}, 32'd255);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
